// File: rtl/hart_issue_scheduler.sv
// Round-robin fine-grained multithreading issue scheduler: one fetch PC per cycle from an eligible hart.
// Optional per-hart issue / idle performance counters are enabled by defining SCHED_PERF_CNT_EN.
module hart_issue_scheduler #(
    parameter int          HART_W    = 2,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          CNT_W     = 4,
    localparam int         NUM_HARTS = 2**HART_W
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_HARTS-1:0] hart_en,
    input  logic                 stall,
    input  logic                 block_valid,
    input  logic [HART_W-1:0]    block_hart,
    input  logic [CNT_W-1:0]     block_cycles,
    input  logic                 wake_valid,
    input  logic [HART_W-1:0]    wake_hart,
    input  logic                 redirect_valid,
    input  logic [HART_W-1:0]    redirect_hart,
    input  logic [31:0]          redirect_pc,
    output logic                 issue_valid,
    output logic [HART_W-1:0]    issue_hart,
    output logic [31:0]          issue_pc,
    output logic [NUM_HARTS-1:0] hart_blocked
`ifdef SCHED_PERF_CNT_EN
    ,
    output logic [NUM_HARTS*32-1:0] issue_cnt,
    output logic [31:0]             idle_cnt
`endif
);

    logic [31:0]       pc_q   [NUM_HARTS];
    logic [31:0]       pc_d   [NUM_HARTS];
    logic [CNT_W-1:0]  cnt_q  [NUM_HARTS];
    logic [CNT_W-1:0]  cnt_d  [NUM_HARTS];
    logic [HART_W-1:0] last_q, last_d;
    logic              issue_valid_q, issue_valid_d;
    logic [HART_W-1:0] issue_hart_q, issue_hart_d;
    logic [31:0]       issue_pc_q, issue_pc_d;

    logic [NUM_HARTS-1:0] elig;
    logic                 sel_found;
    logic [HART_W-1:0]    sel;
    logic [HART_W-1:0]    idx;
    logic                 issue_now;

    always_comb begin
        for (int i = 0; i < NUM_HARTS; i++) begin
            hart_blocked[i] = (cnt_q[i] != '0);
        end
        elig = hart_en & ~hart_blocked;
    end

    // Search last+1 .. last+NUM_HARTS; the wrap makes hart 'last' the final candidate.
    always_comb begin
        sel_found = 1'b0;
        sel       = '0;
        idx       = '0;
        for (int k = 1; k <= NUM_HARTS; k++) begin
            idx = last_q + HART_W'(k);
            if (!sel_found && elig[idx]) begin
                sel_found = 1'b1;
                sel       = idx;
            end
        end
    end

    always_comb begin
        issue_now     = !stall && sel_found;
        issue_valid_d = issue_valid_q;
        issue_hart_d  = issue_hart_q;
        issue_pc_d    = issue_pc_q;
        last_d        = last_q;
        if (!stall) begin
            issue_valid_d = sel_found;
            if (sel_found) begin
                issue_hart_d = sel;
                issue_pc_d   = pc_q[sel];
                last_d       = sel;
            end
        end
        for (int i = 0; i < NUM_HARTS; i++) begin
            pc_d[i] = pc_q[i];
            if (issue_now && sel == HART_W'(i)) pc_d[i] = pc_q[i] + 32'd4;
            if (redirect_valid && redirect_hart == HART_W'(i)) pc_d[i] = redirect_pc;

            // Block beats wake, wake beats the natural decrement.
            cnt_d[i] = (cnt_q[i] != '0) ? cnt_q[i] - CNT_W'(1) : '0;
            if (wake_valid && wake_hart == HART_W'(i)) cnt_d[i] = '0;
            if (block_valid && block_cycles != '0 && block_hart == HART_W'(i)) cnt_d[i] = block_cycles;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            issue_valid_q <= 1'b0;
            issue_hart_q  <= '0;
            issue_pc_q    <= '0;
            last_q        <= '1;
            for (int i = 0; i < NUM_HARTS; i++) begin
                pc_q[i]  <= RESET_PC;
                cnt_q[i] <= '0;
            end
        end else begin
            issue_valid_q <= issue_valid_d;
            issue_hart_q  <= issue_hart_d;
            issue_pc_q    <= issue_pc_d;
            last_q        <= last_d;
            for (int i = 0; i < NUM_HARTS; i++) begin
                pc_q[i]  <= pc_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign issue_valid = issue_valid_q;
    assign issue_hart  = issue_hart_q;
    assign issue_pc    = issue_pc_q;

`ifdef SCHED_PERF_CNT_EN
    logic [31:0] issue_cnt_q [NUM_HARTS];
    logic [31:0] idle_cnt_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idle_cnt_q <= '0;
            for (int i = 0; i < NUM_HARTS; i++) issue_cnt_q[i] <= '0;
        end else if (!stall) begin
            if (sel_found) issue_cnt_q[sel] <= issue_cnt_q[sel] + 32'd1;
            else           idle_cnt_q       <= idle_cnt_q + 32'd1;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_HARTS; i++) issue_cnt[32*i +: 32] = issue_cnt_q[i];
    end
    assign idle_cnt = idle_cnt_q;
`endif

endmodule

// File: tb/tb_hart_issue_scheduler.sv
// Self-checking bench for hart_issue_scheduler: a reference model pushes expected issue results
// into a queue as each cycle's stimulus is applied; they are popped and compared after the edge.
module tb_hart_issue_scheduler;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  hart_en = 4'b0000;
    logic        stall = 1'b0;
    logic        block_valid = 1'b0;
    logic [1:0]  block_hart = 2'd0;
    logic [3:0]  block_cycles = 4'd0;
    logic        wake_valid = 1'b0;
    logic [1:0]  wake_hart = 2'd0;
    logic        redirect_valid = 1'b0;
    logic [1:0]  redirect_hart = 2'd0;
    logic [31:0] redirect_pc = 32'd0;
    logic        issue_valid;
    logic [1:0]  issue_hart;
    logic [31:0] issue_pc;
    logic [3:0]  hart_blocked;
`ifdef SCHED_PERF_CNT_EN
    logic [127:0] issue_cnt;
    logic [31:0]  idle_cnt;
`endif

    hart_issue_scheduler dut (
        .clk(clk), .reset_n(reset_n), .hart_en(hart_en), .stall(stall),
        .block_valid(block_valid), .block_hart(block_hart), .block_cycles(block_cycles),
        .wake_valid(wake_valid), .wake_hart(wake_hart),
        .redirect_valid(redirect_valid), .redirect_hart(redirect_hart), .redirect_pc(redirect_pc),
        .issue_valid(issue_valid), .issue_hart(issue_hart), .issue_pc(issue_pc),
        .hart_blocked(hart_blocked)
`ifdef SCHED_PERF_CNT_EN
        , .issue_cnt(issue_cnt), .idle_cnt(idle_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [1:0]  h;
        logic [31:0] pc;
        logic [3:0]  blk;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    logic [31:0] m_pc  [4];
    int          m_cnt [4];
    int          m_last = 3;
    logic        m_v = 1'b0;
    logic [1:0]  m_h = 2'd0;
    logic [31:0] m_p = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic int next_sel();
        int s;
        s = -1;
        for (int j = 1; j <= 4; j++) begin
            int c;
            c = (m_last + j) % 4;
            if (s < 0 && hart_en[c] && m_cnt[c] == 0) s = c;
        end
        return s;
    endfunction

    task automatic step();
        exp_t e;
        int   s;
        if (!reset_n) begin
            m_v = 1'b0; m_h = 2'd0; m_p = 32'd0; m_last = 3;
            for (int i = 0; i < 4; i++) begin
                m_pc[i] = 32'd0;
                m_cnt[i] = 0;
            end
        end else begin
            s = next_sel();
            if (!stall) begin
                m_v = (s >= 0);
                if (s >= 0) begin
                    m_h = 2'(s);
                    m_p = m_pc[s];
                    m_pc[s] = m_pc[s] + 32'd4;
                    m_last = s;
                end
            end
            if (redirect_valid) m_pc[redirect_hart] = redirect_pc;
            for (int i = 0; i < 4; i++) begin
                if (m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
            end
            if (wake_valid) m_cnt[wake_hart] = 0;
            if (block_valid && block_cycles != 4'd0) m_cnt[block_hart] = int'(block_cycles);
        end
        e.v = m_v; e.h = m_h; e.pc = m_p;
        for (int i = 0; i < 4; i++) e.blk[i] = (m_cnt[i] != 0);
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("issue_valid",  {31'd0, issue_valid}, {31'd0, e.v});
        chk("issue_hart",   {30'd0, issue_hart},  {30'd0, e.h});
        chk("issue_pc",     issue_pc, e.pc);
        chk("hart_blocked", {28'd0, hart_blocked}, {28'd0, e.blk});
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin : main
        logic [31:0] old_pc;
        logic [1:0]  fz_h;
        logic [31:0] fz_p;
        bit          seen;

        // Reset
        reset_n = 1'b0;
        steps(2);
        chk("reset_valid", {31'd0, issue_valid}, 32'd0);

        // All harts enabled: 0,1,2,3 at PC 0 then again at PC 4
        reset_n = 1'b1;
        hart_en = 4'b1111;
        step();
        chk("first_hart", {30'd0, issue_hart}, 32'd0);
        steps(7);
        chk("rr_hart3", {30'd0, issue_hart}, 32'd3);
        chk("rr_pc4", issue_pc, 32'd4);

        // Only harts 0 and 2
        hart_en = 4'b0101;
        steps(6);

        // Block hart 1 for 3 cycles
        hart_en = 4'b1111;
        block_valid = 1'b1; block_hart = 2'd1; block_cycles = 4'd3;
        step();
        block_valid = 1'b0;
        chk("blk_load", {28'd0, hart_blocked}, 32'b0010);
        steps(6);

        // Block then early wake after one cycle
        block_valid = 1'b1; block_hart = 2'd1; block_cycles = 4'd7;
        step();
        block_valid = 1'b0;
        wake_valid = 1'b1; wake_hart = 2'd1;
        step();
        wake_valid = 1'b0;
        chk("wake_clr", {28'd0, hart_blocked}, 32'd0);
        steps(4);

        // Zero-length block ignored; block and wake together: block wins
        block_valid = 1'b1; block_hart = 2'd2; block_cycles = 4'd0;
        step();
        block_hart = 2'd3; block_cycles = 4'd2;
        wake_valid = 1'b1; wake_hart = 2'd3;
        step();
        block_valid = 1'b0; wake_valid = 1'b0;
        chk("blk_wins", {28'd0, hart_blocked}, 32'b1000);
        steps(3);

        // Redirect hart 2 in the cycle it is issued
        for (int n = 0; n < 8 && next_sel() != 2; n++) step();
        old_pc = m_pc[2];
        redirect_valid = 1'b1; redirect_hart = 2'd2; redirect_pc = 32'h100;
        step();
        redirect_valid = 1'b0;
        chk("redir_old", issue_pc, old_pc);
        seen = 1'b0;
        for (int n = 0; n < 8 && !seen; n++) begin
            step();
            if (issue_valid && issue_hart == 2'd2) seen = 1'b1;
        end
        chk("redir_new", seen ? issue_pc : 32'hDEAD_BEEF, 32'h100);
        seen = 1'b0;
        for (int n = 0; n < 8 && !seen; n++) begin
            step();
            if (issue_valid && issue_hart == 2'd2) seen = 1'b1;
        end
        chk("redir_inc", seen ? issue_pc : 32'hDEAD_BEEF, 32'h104);

        // Stall for 5 cycles mid-rotation
        fz_h = issue_hart; fz_p = issue_pc;
        stall = 1'b1;
        steps(5);
        chk("stall_hart", {30'd0, issue_hart}, {30'd0, fz_h});
        chk("stall_pc", issue_pc, fz_p);
        stall = 1'b0;
        step();
        chk("stall_resume", {30'd0, issue_hart}, {30'd0, 2'(fz_h + 2'd1)});
        steps(4);

        // Nothing enabled: valid drops, hart/pc hold
        hart_en = 4'b0000;
        steps(2);
        hart_en = 4'b1111;
        steps(2);

        // Reset mid-stream
        reset_n = 1'b0;
        step();
        chk("midrst_valid", {31'd0, issue_valid}, 32'd0);
        reset_n = 1'b1;
        step();
        chk("midrst_hart", {30'd0, issue_hart}, 32'd0);
        chk("midrst_pc", issue_pc, 32'd0);
        steps(7);
`ifdef SCHED_PERF_CNT_EN
        for (int i = 0; i < 4; i++) chk("issue_cnt", issue_cnt[32*i +: 32], 32'd2);
        chk("idle_cnt", idle_cnt, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
